// File: rtl/spike_frame_sequencer.sv
// spike_frame_sequencer
//   Drives the STDP layer. It loads one image as a stream of spike-time words,
//   then sweeps time_val across the presentation window. In testing mode it
//   captures the layer's winning neuron and offers it on a valid/ready stream.
//
// Ports
//   clk, rst        single clock; asynchronous active-high reset
//   training_mode   mode of the next frame, sampled on its first accepted beat
//   in_valid/ready  spike-time beat handshake (ready only while loading)
//   in_data         spike time for the word at the current load index
//   spike_times     frame buffer to the layer; word i = i-th accepted beat
//   time_val        presentation time to the layer
//   training        latched frame mode to the layer
//   winning_neuron  layer classification, sampled in CAPTURE
//   res_valid/ready testing result handshake
//   res_data        captured winning neuron
//   frame_done      one-cycle pulse on the last cycle of every frame's run
module spike_frame_sequencer #(
  parameter int NUM_SPIKES     = 784,
  parameter int TIME_PERIOD    = 16,
  parameter int TESTING_PERIOD = 8,
  parameter int TIME_W         = 5,
  parameter int NEURON_W       = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         training_mode,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [TIME_W-1:0]            in_data,
  output logic [NUM_SPIKES*TIME_W-1:0] spike_times,
  output logic [TIME_W-1:0]            time_val,
  output logic                         training,
  input  logic [NEURON_W-1:0]          winning_neuron,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [NEURON_W-1:0]          res_data,
  output logic                         frame_done
);

  localparam int IDX_W = (NUM_SPIKES > 1) ? $clog2(NUM_SPIKES) : 1;

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_CAPTURE, S_RESULT} state_t;

  state_t                              state_q, state_d;
  logic [IDX_W-1:0]                    load_idx_q, load_idx_d;
  logic [TIME_W-1:0]                   time_val_q, time_val_d;
  logic                                training_q, training_d;
  logic                                res_valid_q, res_valid_d;
  logic [NEURON_W-1:0]                 res_data_q, res_data_d;
  logic [NUM_SPIKES-1:0][TIME_W-1:0]   spk_q;
  logic                                in_ready_c, frame_done_c, in_fire;
  logic [TIME_W-1:0]                   win_last;

  // Last time_val of the window depends on the latched frame mode.
  assign win_last = training_q ? TIME_W'(TIME_PERIOD - 1) : TIME_W'(TESTING_PERIOD - 1);
  assign in_fire  = (state_q == S_LOAD) && in_valid;

  always_comb begin
    state_d      = state_q;
    load_idx_d   = load_idx_q;
    time_val_d   = time_val_q;
    training_d   = training_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    in_ready_c   = 1'b0;
    frame_done_c = 1'b0;
    case (state_q)
      S_LOAD: begin
        in_ready_c = 1'b1;
        if (in_valid) begin
          if (load_idx_q == '0) training_d = training_mode;
          if (load_idx_q == IDX_W'(NUM_SPIKES - 1)) begin
            load_idx_d = '0;
            state_d    = S_RUN;
          end else begin
            load_idx_d = load_idx_q + IDX_W'(1);
          end
        end
      end
      S_RUN: begin
        if (time_val_q == win_last) begin
          time_val_d = '0;
          if (training_q) begin
            frame_done_c = 1'b1;
            state_d      = S_LOAD;
          end else begin
            state_d      = S_CAPTURE;
          end
        end else begin
          time_val_d = time_val_q + TIME_W'(1);
        end
      end
      S_CAPTURE: begin
        res_data_d   = winning_neuron;
        res_valid_d  = 1'b1;
        frame_done_c = 1'b1;
        state_d      = S_RESULT;
      end
      S_RESULT: begin
        // res_valid_q is always 1 here, so res_ready alone completes the handshake.
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_LOAD;
      load_idx_q  <= '0;
      time_val_q  <= '0;
      training_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      load_idx_q  <= load_idx_d;
      time_val_q  <= time_val_d;
      training_q  <= training_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  // Frame buffer: written only on accepted beats, so it is frozen outside LOAD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          spk_q <= '0;
    else if (in_fire) spk_q[load_idx_q] <= in_data;
  end

  // in_ready is masked by rst so every output reads 0 while reset is held.
  assign in_ready    = in_ready_c & ~rst;
  assign frame_done  = frame_done_c;
  assign spike_times = spk_q;
  assign time_val    = time_val_q;
  assign training    = training_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;

endmodule

// File: tb/tb_spike_frame_sequencer.sv
// Directed bench for spike_frame_sequencer; results are tracked with a
// scoreboard queue filled at capture and drained at the result handshake.
module tb_spike_frame_sequencer;
  localparam int NS = 784, TP = 16, TSP = 8, TW = 5, NW = 4;

  logic clk = 1'b0, rst = 1'b1, training_mode = 1'b0, in_valid = 1'b0, res_ready = 1'b0;
  logic [TW-1:0]    in_data = '0;
  logic [NW-1:0]    winning_neuron = '0;
  logic             in_ready, training, res_valid, frame_done;
  logic [NS*TW-1:0] spike_times;
  logic [TW-1:0]    time_val;
  logic [NW-1:0]    res_data;

  spike_frame_sequencer #(.NUM_SPIKES(NS), .TIME_PERIOD(TP), .TESTING_PERIOD(TSP),
                          .TIME_W(TW), .NEURON_W(NW)) dut (
    .clk(clk), .rst(rst), .training_mode(training_mode), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .spike_times(spike_times),
    .time_val(time_val), .training(training), .winning_neuron(winning_neuron),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [NS-1:0][TW-1:0] exp_spk;
  logic [NW-1:0]         sb[$];
  int n_cmp = 0, n_err = 0;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_spk(input string tag);
    int bad = 0;
    for (int i = NS - 1; i >= 0; i--)
      if (spike_times[i*TW +: TW] !== exp_spk[i]) bad = i;
    n_cmp++;
    assert (spike_times === exp_spk) else begin
      n_err++;
      $error("FAIL %s: word %0d observed %0h expected %0h", tag, bad,
             spike_times[bad*TW +: TW], exp_spk[bad]);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_time_val"}, time_val, 0);
    chk({tag, "_training"}, training, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_data"}, res_data, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_spike_nz"}, (spike_times != '0), 0);
  endtask

  // Word i carries (i+off)%16. gappy inserts an idle cycle with junk data
  // and the opposite mode before every beat; flip inverts mode after beat 0.
  task automatic load_frame(input bit mode, input int off, input bit gappy, input bit flip);
    for (int i = 0; i < NS; i++) begin
      if (gappy) begin
        in_valid = 1'b0; in_data = 5'h1f; training_mode = ~mode;
        step();
        chk("gap_in_ready", in_ready, 1);
      end
      in_valid      = 1'b1;
      in_data       = TW'((i + off) % 16);
      training_mode = (flip && i > 0) ? ~mode : mode;
      exp_spk[i]    = in_data;
      chk("load_in_ready", in_ready, 1);
      step();
    end
    in_valid = 1'b0; training_mode = 1'b0;
  endtask

  task automatic run_window(input bit mode);
    int len = mode ? TP : TSP;
    for (int t = 0; t < len; t++) begin
      chk("run_time_val", time_val, t);
      chk("run_in_ready", in_ready, 0);
      chk("run_training", training, mode);
      chk("run_frame_done", frame_done, (mode && t == len - 1));
      chk("run_res_valid", res_valid, 0);
      step();
    end
    if (mode) begin
      chk("trn_end_in_ready", in_ready, 1);
      chk("trn_end_frame_done", frame_done, 0);
      chk("trn_end_time_val", time_val, 0);
      chk("trn_end_res_valid", res_valid, 0);
    end
  endtask

  // Entered on the capture cycle; holds res_ready low for 'hold' result cycles.
  task automatic capture_result(input logic [NW-1:0] wn, input int hold);
    logic [NW-1:0] exp;
    int w = 0;
    chk("cap_frame_done", frame_done, 1);
    chk("cap_res_valid", res_valid, 0);
    chk("cap_time_val", time_val, 0);
    chk("cap_in_ready", in_ready, 0);
    res_ready = 1'b1;             // must be ignored on the capture cycle
    sb.push_back(wn);
    step();
    winning_neuron = ~wn;         // result must not follow the input any more
    while (!res_valid && w < 4) begin step(); w++; end
    chk("res_valid_seen", res_valid, 1);
    exp = (sb.size() > 0) ? sb[0] : '0;
    for (int k = 0; k < hold; k++) begin
      res_ready = 1'b0;
      chk("hold_res_valid", res_valid, 1);
      chk("hold_res_data", res_data, exp);
      chk("hold_in_ready", in_ready, 0);
      step();
    end
    res_ready = 1'b1;
    chk("hs_res_valid", res_valid, 1);
    if (sb.size() > 0) exp = sb.pop_front();
    chk("hs_res_data", res_data, exp);
    step();
    chk("post_res_valid", res_valid, 0);
    chk("post_in_ready", in_ready, 1);
  endtask

  initial begin
    int c0;
    // Reset state, while held and on release.
    #2;
    chk_all_zero("rst_held");
    step(); step();
    rst = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1);
    chk("rel_time_val", time_val, 0);
    chk("rel_res_valid", res_valid, 0);

    // Training frame, words i%16.
    load_frame(1'b1, 0, 1'b0, 1'b0);
    chk_spk("trn_words");
    run_window(1'b1);

    // Testing frame, winning neuron 7, consumer stalls 5 cycles.
    winning_neuron = 4'd7;
    load_frame(1'b0, 3, 1'b0, 1'b0);
    chk_spk("tst_words");
    run_window(1'b0);
    capture_result(4'd7, 5);

    // Gappy load into a testing frame.
    winning_neuron = 4'd9;
    load_frame(1'b0, 5, 1'b1, 1'b0);
    chk_spk("gap_words");
    run_window(1'b0);
    capture_result(4'd9, 0);

    // training_mode flipped after the first beat.
    load_frame(1'b1, 7, 1'b0, 1'b1);
    chk_spk("flip_words");
    run_window(1'b1);

    // Reset in the middle of RUN, then a full reload.
    load_frame(1'b0, 1, 1'b0, 1'b0);
    step(); step(); step();
    chk("mid_time_val", time_val, 3);
    rst = 1'b1;
    #1;
    chk_all_zero("rst_run");
    step();
    rst = 1'b0;
    #1;
    chk("rst_run_in_ready", in_ready, 1);
    load_frame(1'b1, 2, 1'b0, 1'b0);
    chk_spk("reload_words");
    run_window(1'b1);

    // Reset while a result is pending drops it.
    winning_neuron = 4'd5;
    load_frame(1'b0, 4, 1'b0, 1'b0);
    run_window(1'b0);
    res_ready = 1'b0;
    step();
    chk("pend_res_valid", res_valid, 1);
    chk("pend_res_data", res_data, 5);
    rst = 1'b1;
    #1;
    chk_all_zero("rst_res");
    step();
    rst = 1'b0;
    #1;

    // Back-to-back testing frames with res_ready tied high.
    res_ready = 1'b1;
    for (int f = 0; f < 2; f++) begin
      c0 = cyc;
      winning_neuron = (f == 0) ? 4'd3 : 4'd12;
      load_frame(1'b0, f, 1'b0, 1'b0);
      run_window(1'b0);
      capture_result((f == 0) ? 4'd3 : 4'd12, 0);
      chk("b2b_frame_cycles", cyc - c0, NS + TSP + 2);
    end

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
